multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Parametrised multicycle ARM control unit: main FSM, ALU decoder, PC-source and instruction decoder in one block.
//  Sits between instruction register/condlogic and the datapath muxes.
//  Extends the previous decoder with: wider ALU op set (EOR, MOV, CMP/TST no-write), memory ready handshake,
//  undefined-op trap, retired-instruction counter.
// PARAMETERS
//  ALUCTRL_W  3   width of ALUControl (>=3 required for EOR/MOV encodings)
//  MEM_HS     1   1: FETCH/MEMREAD/MEMWRITE wait for MemReady; 0: MemReady ignored (treated as 1)
//  CNT_W      32  width of RetireCount
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          asynchronous, active-low reset
//  Op          in   2          Instr[27:26]
//  Funct       in   6          Instr[25:20]
//  Rd          in   4          Instr[15:12]
//  MemReady    in   1          memory completes access this cycle
//  MemReq      out  1          memory access request (FETCH, MEMREAD, MEMWRITE)
//  FlagW       out  2          [1]=NZ write, [0]=CV write
//  PCS         out  1          PC written by branch or Rd==15 writeback
//  NextPC      out  1          PC+4 update
//  RegW        out  1          register file write (pre-condition)
//  MemW        out  1          memory write (pre-condition)
//  NoWrite     out  1          current DP op is CMP/TST (suppresses RegW in ALUWB)
//  IRWrite     out  1          instruction register load
//  AdrSrc      out  1          0=PC, 1=ALUOut
//  ResultSrc   out  2          00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA     out  2          00=Rn, 01=PC, 10=ALUOut
//  ALUSrcB     out  2          00=Rm, 01=ExtImm, 10=const 4
//  ImmSrc      out  2          =Op
//  RegSrc      out  2          [0]=(Op==10), [1]=(Op==01)
//  ALUControl  out  ALUCTRL_W  000 ADD,001 SUB,010 AND,011 ORR,100 EOR,101 MOV(pass B)
//  Undef       out  1          one-cycle pulse in UNDEF state
//  RetireCount out  CNT_W      instructions completed since reset
// BEHAVIOUR
//  - Reset low: state=FETCH, RetireCount=0; while low, MemReq/IRWrite/NextPC/RegW/MemW/PCS/Undef forced 0,
//    others at FETCH values. Release: FETCH outputs from first edge. Reset mid-instruction aborts, no write.
//  - Moore outputs from state; ALUControl/FlagW/NoWrite combinational from Funct when ALUOp=1, else 0.
//  - Mem wait (rdy = MemReady | ~MEM_HS): FETCH/MEMREAD/MEMWRITE hold until rdy; MemReq high throughout;
//    IRWrite, NextPC, MemW asserted in the rdy cycle only; Data latched on MEMREAD rdy.
//  - States / outputs / next:
//    FETCH    AdrSrc0 A01 B10 Res10 IRWrite,NextPC(rdy)     -> DECODE on rdy
//    DECODE   A01 B10 Res10                                 -> Op00&~F5:EXECR  Op00&F5:EXECI  Op01:MEMADR  Op10:BRANCH  Op11:UNDEF
//    MEMADR   A00 B01                                       -> F0:MEMREAD  else MEMWRITE
//    MEMREAD  AdrSrc1 Res00                                 -> MEMWB on rdy
//    MEMWB    Res01 RegW                                    -> FETCH
//    MEMWRITE AdrSrc1 Res00 MemW(rdy)                       -> FETCH on rdy
//    EXECR    A00 B00 ALUOp                                 -> ALUWB
//    EXECI    A00 B01 ALUOp                                 -> ALUWB
//    ALUWB    Res00 RegW=~NoWrite, ALUOp held for FlagW     -> FETCH
//    BRANCH   A10 B01 Res10 Branch                          -> FETCH
//    UNDEF    Undef=1                                       -> FETCH
//  - ALU decode on Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV, 1010 CMP(SUB,NoWrite),
//    1000 TST(AND,NoWrite); others -> ADD, RegW suppressed, Undef pulse in ALUWB.
//  - FlagW[1]=Funct[0]|NoWrite; FlagW[0]=FlagW[1]&(op in ADD,SUB,CMP); FlagW only nonzero in ALUWB.
//  - PCS = (Rd==15 & RegW) | Branch.
//  - RetireCount +1 on exit of MEMWB, MEMWRITE(rdy), ALUWB, BRANCH; UNDEF not counted; wraps at 2^CNT_W.
// TESTING
//  1 ADD R1,R2,R3 (Op00,F=001000), MemReady=1 -> FETCH,DECODE,EXECR,ALUWB; RegW=1 in ALUWB, ALUControl=000, count=1.
//  2 LDR, MemReady low 3 cycles in MEMREAD -> state holds 3 cycles, MemReq=1, RegW only in MEMWB, 5+3 cycles.
//  3 CMP (F=010101) -> ALUControl=001, NoWrite=1, RegW=0, FlagW=11 in ALUWB.
//  4 Op=11 -> UNDEF after DECODE, Undef pulse 1 cycle, count unchanged, back to FETCH.
//  5 B (Op10) -> PCS=1 in BRANCH; MOV PC,R1 (F=011010,Rd=15) -> PCS=1 in ALUWB, ALUControl=101.
//  6 reset low mid-MEMWRITE -> MemW=0 immediately (async), state FETCH, count=0; MEM_HS=0 ignores MemReady=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle ARM control unit (main FSM, ALU decoder, PC-source, instruction decoder)
module multicycle_ctrl #(
    parameter int ALUCTRL_W = 3,
    parameter bit MEM_HS    = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 MemReady,
    output logic                 MemReq,
    output logic [1:0]           FlagW,
    output logic                 PCS,
    output logic                 NextPC,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 NoWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Undef,
    output logic [CNT_W-1:0]     RetireCount
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_UNDEF
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy, alu_op, mem_req, ir_write, next_pc, reg_w, mem_w, branch, undef;
    logic [2:0]       ctrl;
    logic             nw, bad, arith, retire;

    assign rdy = MemReady | ~MEM_HS;

    // ALU decode of Funct[4:1]: control code, no-write compares and unknown-op trap
    always_comb begin
        ctrl  = 3'b000;
        nw    = 1'b0;
        bad   = 1'b0;
        arith = 1'b0;
        case (Funct[4:1])
            4'b0100: arith = 1'b1;
            4'b0010: begin ctrl = 3'b001; arith = 1'b1; end
            4'b0000: ctrl = 3'b010;
            4'b1100: ctrl = 3'b011;
            4'b0001: ctrl = 3'b100;
            4'b1101: ctrl = 3'b101;
            4'b1010: begin ctrl = 3'b001; nw = 1'b1; arith = 1'b1; end
            4'b1000: begin ctrl = 3'b010; nw = 1'b1; end
            default: bad = 1'b1;
        endcase
    end

    // Next state and Moore datapath selects; memory states stall until rdy
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        ir_write  = 1'b0;
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        undef     = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = rdy;
                next_pc   = rdy;
                state_d   = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = Op == 2'b00 ? (Funct[5] ? S_EXECI : S_EXECR) :
                            Op == 2'b01 ? S_MEMADR : Op == 2'b10 ? S_BRANCH : S_UNDEF;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                state_d = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                mem_w   = rdy;
                state_d = rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                alu_op  = 1'b1;
                reg_w   = ~nw & ~bad;
                undef   = bad;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_UNDEF: begin
                undef   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are forced low while reset is asserted; ALU fields only live while ALUOp is set
    always_comb begin
        MemReq      = mem_req & reset;
        IRWrite     = ir_write & reset;
        NextPC      = next_pc & reset;
        RegW        = reg_w & reset;
        MemW        = mem_w & reset;
        Undef       = undef & reset;
        PCS         = ((Rd == 4'd15 & reg_w) | branch) & reset;
        ALUControl  = alu_op ? ALUCTRL_W'(ctrl) : '0;
        NoWrite     = alu_op & nw;
        FlagW[1]    = state_q == S_ALUWB & (Funct[0] | nw);
        FlagW[0]    = state_q == S_ALUWB & (Funct[0] | nw) & arith;
        ImmSrc      = Op;
        RegSrc      = {Op == 2'b01, Op == 2'b10};
        retire      = state_q == S_MEMWB | (state_q == S_MEMWRITE & rdy) |
                      state_q == S_ALUWB | state_q == S_BRANCH;
        cnt_d       = cnt_q + CNT_W'(retire);
        RetireCount = cnt_q;
    end

    // State and retired-instruction counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked per instruction against a scoreboard
module tb_multicycle_ctrl;
    logic clk = 1'b0, reset = 1'b0, MemReady = 1'b0, mr0 = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic MemReq, PCS, NextPC, RegW, MemW, NoWrite, IRWrite, AdrSrc, Undef;
    logic [1:0] FlagW, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [31:0] RetireCount;
    logic MemReq1, PCS1, NextPC1, RegW1, MemW1, NoWrite1, IRWrite1, AdrSrc1, Undef1;
    logic [1:0] FlagW1, ResultSrc1, ALUSrcA1, ALUSrcB1, ImmSrc1, RegSrc1;
    logic [2:0] ALUControl1;
    logic [31:0] RetireCount1;

    multicycle_ctrl #(.ALUCTRL_W(3), .MEM_HS(1'b1), .CNT_W(32)) u0 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .MemReq(MemReq), .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .ALUControl(ALUControl), .Undef(Undef), .RetireCount(RetireCount));

    multicycle_ctrl #(.ALUCTRL_W(3), .MEM_HS(1'b0), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(mr0),
        .MemReq(MemReq1), .FlagW(FlagW1), .PCS(PCS1), .NextPC(NextPC1), .RegW(RegW1), .MemW(MemW1),
        .NoWrite(NoWrite1), .IRWrite(IRWrite1), .AdrSrc(AdrSrc1), .ResultSrc(ResultSrc1),
        .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1), .ImmSrc(ImmSrc1), .RegSrc(RegSrc1),
        .ALUControl(ALUControl1), .Undef(Undef1), .RetireCount(RetireCount1));

    always #5 clk = ~clk;

    localparam int K_DP = 0, K_LDR = 1, K_STR = 2, K_B = 3, K_UNDEF = 4;

    typedef struct {
        int kind; int cycles; int regw; int memw; int pcs; int undef;
        int nw; int alu; int flag; int memreq; int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int n_cmp = 0, n_err = 0, n_instr = 0;
    bit mon_en = 1'b0, pend = 1'b0;
    logic [31:0] model_cnt = 0, prev_cnt = 0;
    int a_cyc = 0, a_regw = 0, a_memw = 0, a_pcs = 0, a_undef = 0, a_nw = 0, a_alu = 0, a_flag = 0, a_mr = 0;

    task automatic chk(input string nm, input int act, input int ex);
        n_cmp++;
        if (act !== ex) begin
            n_err++;
            $display("FAIL %s (instr %0d): got %0d expected %0d", nm, n_instr, act, ex);
        end
    endtask

    // ALU table: operation code, legality, compare/test, and whether C/V flags are written
    function automatic void ref_alu(input logic [3:0] c, output int code, output bit ok,
                                    output bit nw, output bit ar);
        code = 0; ok = 1'b1; nw = 1'b0; ar = 1'b0;
        case (c)
            4'b0100: ar = 1'b1;
            4'b0010: begin code = 1; ar = 1'b1; end
            4'b0000: code = 2;
            4'b1100: code = 3;
            4'b0001: code = 4;
            4'b1101: code = 5;
            4'b1010: begin code = 1; nw = 1'b1; ar = 1'b1; end
            4'b1000: begin code = 2; nw = 1'b1; end
            default: ok = 1'b0;
        endcase
    endfunction

    // Issue one instruction: push its expected summary, then drive it cycle by cycle
    task automatic issue(input int kind, input logic [5:0] f, input logic [3:0] rd,
                         input int wf, input int wm);
        exp_t x;
        int code, len;
        bit ok, nw, ar, f1, mem, mr;
        mem = kind == K_LDR || kind == K_STR;
        ref_alu(f[4:1], code, ok, nw, ar);
        f1 = f[0] | nw;
        x.kind   = kind;
        x.regw   = (kind == K_DP && ok && !nw) || kind == K_LDR;
        x.memw   = kind == K_STR;
        x.pcs    = kind == K_B || (x.regw == 1 && rd == 4'd15);
        x.undef  = kind == K_UNDEF || (kind == K_DP && !ok);
        x.nw     = (kind == K_DP && nw) ? 2 : 0;
        x.alu    = kind == K_DP ? code : 0;
        x.flag   = kind == K_DP ? {30'd0, f1, f1 & ar} : 0;
        x.memreq = 1 + wf + (mem ? 1 + wm : 0);
        len = kind == K_DP ? 4 + wf : kind == K_LDR ? 5 + wf + wm : kind == K_STR ? 4 + wf + wm : 3 + wf;
        x.cycles = len;
        if (kind != K_UNDEF) model_cnt = model_cnt + 1;
        x.cnt = int'(model_cnt);
        sb.push_back(x);
        Op = kind == K_DP ? 2'b00 : mem ? 2'b01 : kind == K_B ? 2'b10 : 2'b11;
        Funct = f;
        Rd = rd;
        for (int k = 0; k < len; k++) begin
            mr = 1'($urandom_range(0, 1));
            if (k <= wf) mr = k == wf;
            else if (mem && k >= wf + 3) mr = k == wf + 3 + wm;
            MemReady = mr;
            @(posedge clk); #1;
        end
    endtask

    // Monitor: accumulate per-instruction activity, compare when the DUT finishes an instruction
    always @(negedge clk) begin
        if (mon_en) begin
            if (pend || RetireCount != prev_cnt) begin
                if (sb.size() == 0) chk("unexpected_retire", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("cycles", a_cyc, e.cycles);
                    chk("regw", a_regw, e.regw);
                    chk("memw", a_memw, e.memw);
                    chk("pcs", a_pcs, e.pcs);
                    chk("undef", a_undef, e.undef);
                    chk("nowrite", a_nw, e.nw);
                    chk("alucontrol", a_alu, e.alu);
                    chk("flagw", a_flag, e.flag);
                    chk("memreq", a_mr, e.memreq);
                    chk("retirecount", int'(RetireCount), e.cnt);
                    n_instr++;
                end
                {a_cyc, a_regw, a_memw, a_pcs, a_undef, a_nw, a_alu, a_flag, a_mr} = '0;
                pend = 1'b0;
            end
            prev_cnt = RetireCount;
            a_cyc++;
            a_regw += int'(RegW);
            a_memw += int'(MemW);
            a_pcs += int'(PCS);
            a_undef += int'(Undef);
            a_nw += int'(NoWrite);
            a_mr += int'(MemReq);
            a_alu |= int'(ALUControl);
            a_flag |= int'(FlagW);
            if (sb.size() > 0 && sb[0].kind == K_UNDEF && Undef) pend = 1'b1;
        end
    end

    initial begin
        logic [5:0] f;
        int kind;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_memreq", int'(MemReq), 0);
        chk("rst_irwrite", int'(IRWrite), 0);
        chk("rst_nextpc", int'(NextPC), 0);
        chk("rst_count", int'(RetireCount), 0);
        chk("rst_alusrca", int'(ALUSrcA), 1);
        chk("rst_alusrcb", int'(ALUSrcB), 2);
        chk("rst_resultsrc", int'(ResultSrc), 2);
        @(posedge clk); #1;
        reset = 1'b1;
        mon_en = 1'b1;
        issue(K_DP, 6'b001000, 4'd1, 0, 0);
        issue(K_LDR, 6'b011001, 4'd4, 0, 3);
        issue(K_DP, 6'b010101, 4'd0, 1, 0);
        issue(K_UNDEF, 6'b000000, 4'd0, 0, 0);
        issue(K_B, 6'b100000, 4'd0, 2, 0);
        issue(K_DP, 6'b011010, 4'd15, 0, 0);
        issue(K_STR, 6'b011000, 4'd15, 1, 2);
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 4);
            f = 6'($urandom);
            if (kind == K_LDR) f[0] = 1'b1;
            if (kind == K_STR) f[0] = 1'b0;
            issue(kind, f, ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14)),
                  $urandom_range(0, 2), $urandom_range(0, 3));
        end
        MemReady = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #1;
        if (sb.size() > 0) chk("drain", sb.size(), 0);
        mon_en = 1'b0;
        // Reset in the middle of a store; MEM_HS=0 instance runs with MemReady tied low
        reset = 1'b0;
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
        @(negedge clk);
        chk("rst2_count", int'(RetireCount), 0);
        chk("rst2_count_nohs", int'(RetireCount1), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        MemReady = 1'b1;
        @(negedge clk);
        chk("fetch_irwrite", int'(IRWrite), 1);
        chk("nohs_irwrite", int'(IRWrite1), 1);
        @(posedge clk); #1; MemReady = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("memwrite_wait_memw", int'(MemW), 0);
        chk("memwrite_wait_memreq", int'(MemReq), 1);
        chk("memwrite_adrsrc", int'(AdrSrc), 1);
        @(posedge clk); #1; MemReady = 1'b1;
        @(negedge clk);
        chk("memwrite_rdy_memw", int'(MemW), 1);
        chk("nohs_retired", int'(RetireCount1), 1);
        #1 reset = 1'b0;
        #1;
        chk("async_memw", int'(MemW), 0);
        chk("async_memreq", int'(MemReq), 0);
        chk("async_adrsrc", int'(AdrSrc), 0);
        chk("async_alusrcb", int'(ALUSrcB), 2);
        chk("async_count", int'(RetireCount), 0);
        @(posedge clk); #1;
        chk("held_count", int'(RetireCount), 0);
        chk("held_memw", int'(MemW), 0);
        reset = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
